// File: rtl/game_pkg.sv
// Shared types and helpers for the 2048 board mover: directions, FSM states,
// board geometry and the cell index mapping.
package game_pkg;

  localparam int CELL_W  = 4;
  localparam int BOARD_W = 64;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LINE  = 2'd1,
    ST_SPAWN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Linear cell number 4r+c; the nibble of that cell starts at bit idx*4.
  function automatic logic [3:0] idx(input logic [1:0] r, input logic [1:0] c);
    return {r, c};
  endfunction

endpackage

// File: rtl/game_board_mover_if.sv
// Command/status bundle between the controller FSM (master) and the board mover (slave).
interface game_board_mover_if;
  import game_pkg::*;

  logic               load;
  logic [BOARD_W-1:0] load_board;
  logic               start;
  logic [1:0]         dir;
  logic               busy;
  logic               done;
  logic               moved;
  logic               win;
  logic [BOARD_W-1:0] board;

  modport master (
    output load, load_board, start, dir,
    input  busy, done, moved, win, board
  );

  modport slave (
    input  load, load_board, start, dir,
    output busy, done, moved, win, board
  );

endinterface

// File: rtl/game_row_push_merge.sv
// Combinational 2048 line slide: compacts tiles toward one end and merges each
// equal adjacent pair once, nearest the destination wall first.
module game_row_push_merge
  import game_pkg::*;
(
  input  logic [4*CELL_W-1:0] line,
  input  logic                push_right,
  output logic [4*CELL_W-1:0] result
);

  logic [CELL_W-1:0] src [4];
  logic [CELL_W-1:0] dst [4];
  logic [2:0]        pos;
  logic              can_merge;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      src[k] = push_right ? line[(3-k)*CELL_W +: CELL_W] : line[k*CELL_W +: CELL_W];
      dst[k] = '0;
    end
    pos       = '0;
    can_merge = 1'b0;
    result    = '0;
    // src[0] is the cell next to the destination wall in both directions.
    for (int k = 0; k < 4; k++) begin
      if (src[k] != '0) begin
        if (can_merge && dst[pos[1:0] - 2'd1] == src[k]) begin
          dst[pos[1:0] - 2'd1] = src[k] + 4'd1;
          can_merge            = 1'b0;
        end else begin
          dst[pos[1:0]] = src[k];
          pos           = pos + 3'd1;
          can_merge     = 1'b1;
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (push_right) result[(3-k)*CELL_W +: CELL_W] = dst[k];
      else            result[k*CELL_W +: CELL_W]     = dst[k];
    end
  end

endmodule

// File: rtl/game_board_mover.sv
// 4x4 2048 board register: applies one move per start, one line per cycle
// through a shared merge unit, then spawns a tile in an empty cell if anything moved.
module game_board_mover
  import game_pkg::*;
#(
  parameter logic [3:0]  WIN_TILE  = 4'd11,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  game_board_mover_if.slave  bus
);

  state_e              state_q, state_n;
  logic [BOARD_W-1:0]  board_q;
  logic [1:0]          dir_q;
  logic [1:0]          idx_q;
  logic                chg_q;
  logic                moved_q;
  logic [3:0]          ptr_q;
  logic [3:0]          cnt_q;
  logic [15:0]         lfsr_q;

  logic [4*CELL_W-1:0] line;
  logic [4*CELL_W-1:0] result;
  logic                line_chg;
  logic                cell_empty;
  logic                lfsr_fb;
  logic                any_win;

  // Gather: rows for left/right, columns for up/down; nibble k runs away from cell 0.
  always_comb begin
    line = '0;
    for (int k = 0; k < 4; k++) begin
      if (dir_q[1]) line[k*CELL_W +: CELL_W] = board_q[{idx(2'(k), idx_q), 2'b00} +: CELL_W];
      else          line[k*CELL_W +: CELL_W] = board_q[{idx(idx_q, 2'(k)), 2'b00} +: CELL_W];
    end
  end

  game_row_push_merge u_merge (
    .line       (line),
    .push_right (dir_q[0]),
    .result     (result)
  );

  assign line_chg   = (result != line);
  assign cell_empty = (board_q[{ptr_q, 2'b00} +: CELL_W] == '0);
  assign lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_n = ST_LINE;
      ST_LINE:  if (idx_q == 2'd3) state_n = (chg_q || line_chg) ? ST_SPAWN : ST_DONE;
      ST_SPAWN: if (cell_empty || cnt_q == 4'd15) state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
    if (bus.load) state_n = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      board_q <= '0;
      dir_q   <= '0;
      idx_q   <= '0;
      chg_q   <= 1'b0;
      moved_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_n;
      lfsr_q  <= {lfsr_q[14:0], lfsr_fb};
      if (bus.load) begin
        board_q <= bus.load_board;
        moved_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.start) begin
              dir_q   <= bus.dir;
              idx_q   <= '0;
              chg_q   <= 1'b0;
              moved_q <= 1'b0;
            end
          end
          ST_LINE: begin
            for (int k = 0; k < 4; k++) begin
              if (dir_q[1]) board_q[{idx(2'(k), idx_q), 2'b00} +: CELL_W] <= result[k*CELL_W +: CELL_W];
              else          board_q[{idx(idx_q, 2'(k)), 2'b00} +: CELL_W] <= result[k*CELL_W +: CELL_W];
            end
            chg_q <= chg_q | line_chg;
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              moved_q <= chg_q | line_chg;
              ptr_q   <= lfsr_q[3:0];
              cnt_q   <= '0;
            end
          end
          ST_SPAWN: begin
            if (cell_empty) begin
              board_q[{ptr_q, 2'b00} +: CELL_W] <= (lfsr_q[6:4] == 3'd0) ? 4'd2 : 4'd1;
            end else begin
              ptr_q <= ptr_q + 4'd1;
              cnt_q <= cnt_q + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    any_win = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (board_q[k*CELL_W +: CELL_W] == WIN_TILE) any_win = 1'b1;
    end
  end

  // A load in the DONE cycle suppresses the pulse: the move is treated as aborted.
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.done  = (state_q == ST_DONE) && !bus.load;
  assign bus.moved = moved_q;
  assign bus.win   = any_win;
  assign bus.board = board_q;

endmodule

// File: tb/tb_game_board_mover.sv
// Scoreboard bench for game_board_mover: directed 2048 moves, aborts and random boards
// compared against a queue-based model of the sliding rules.
module tb_game_board_mover;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_fail;

  game_board_mover_if bus ();

  game_board_mover dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] pre;
    logic [63:0] post;
    logic        moved;
    int          t0;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Slide every line toward its wall with plain queues: collect tiles, pair equal neighbours.
  function automatic logic [63:0] model_move(input logic [63:0] b, input logic [1:0] d);
    logic [63:0] nb;
    int          cells[4];
    int          q[$];
    int          m[$];
    int          v;
    int          r;
    int          c;
    nb = b;
    for (int i = 0; i < 4; i++) begin
      q.delete();
      m.delete();
      for (int j = 0; j < 4; j++) begin
        case (d)
          2'd0:    begin r = i;     c = j;     end
          2'd1:    begin r = i;     c = 3 - j; end
          2'd2:    begin r = j;     c = i;     end
          default: begin r = 3 - j; c = i;     end
        endcase
        cells[j] = r * 4 + c;
      end
      for (int j = 0; j < 4; j++) begin
        v = int'(b[cells[j]*4 +: 4]);
        if (v != 0) q.push_back(v);
      end
      while (q.size() > 0) begin
        v = q.pop_front();
        if (q.size() > 0 && q[0] == v) begin
          void'(q.pop_front());
          m.push_back((v + 1) % 16);
        end else begin
          m.push_back(v);
        end
      end
      for (int j = 0; j < 4; j++) nb[cells[j]*4 +: 4] = (j < m.size()) ? 4'(m[j]) : 4'd0;
    end
    return nb;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding move.
  always @(negedge clk) begin : monitor
    exp_t        e;
    int          lat;
    int          newc;
    logic        bad_val;
    logic [63:0] mask;
    logic [3:0]  a;
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        e   = sb.pop_front();
        lat = cyc - e.t0;
        chk("moved", 64'(bus.moved), 64'(e.moved));
        if (e.moved) begin
          n_vec++;
          if (lat < 6 || lat > 21) begin
            n_fail++;
            $display("FAIL latency_moved: got %0d, expected 6..21", lat);
          end
          newc    = 0;
          bad_val = 1'b0;
          mask    = '0;
          for (int k = 0; k < 16; k++) begin
            a = bus.board[k*4 +: 4];
            if (e.post[k*4 +: 4] != 4'd0) mask[k*4 +: 4] = 4'hF;
            else if (a != 4'd0) begin
              newc++;
              if (a > 4'd2) bad_val = 1'b1;
            end
          end
          chk("kept_cells", bus.board & mask, e.post);
          chk("spawn_count", 64'(newc), 64'd1);
          chk("spawn_value_bad", 64'(bad_val), 64'd0);
        end else begin
          chk("latency_still", 64'(lat), 64'd5);
          chk("board_still", bus.board, e.post);
        end
      end
    end
  end

  task automatic drive_load(input logic [63:0] b);
    bus.load       = 1'b1;
    bus.load_board = b;
    @(negedge clk);
    bus.load       = 1'b0;
  endtask

  task automatic issue_start(input logic [63:0] b, input logic [1:0] d);
    exp_t e;
    e.pre   = b;
    e.post  = model_move(b, d);
    e.moved = (e.post != b);
    e.t0    = cyc;
    sb.push_back(e);
    bus.start = 1'b1;
    bus.dir   = d;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy && sb.size() == 0) return;
    end
    n_vec++;
    n_fail++;
    $display("FAIL timeout: busy=%0d pending=%0d, expected idle with no pending move", bus.busy, sb.size());
    sb.delete();
  endtask

  task automatic run_move(input logic [63:0] b, input logic [1:0] d, input bit poke);
    drive_load(b);
    issue_start(b, d);
    if (poke) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.dir   = ~d;
      @(negedge clk);
      bus.start = 1'b0;
    end
    wait_idle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic spawn_trial(output logic [63:0] res);
    do_reset();
    repeat (3) @(negedge clk);
    run_move(64'h0211, 2'd0, 1'b0);
    res = bus.board;
  endtask

  initial begin
    logic [63:0] b;
    logic [63:0] ra;
    logic [63:0] rb;
    int          rv;
    n_vec          = 0;
    n_fail         = 0;
    bus.load       = 1'b0;
    bus.load_board = '0;
    bus.start      = 1'b0;
    bus.dir        = 2'd0;
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("reset_board", bus.board, 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_moved", 64'(bus.moved), 64'd0);
    chk("reset_win", 64'(bus.win), 64'd0);

    run_move(64'h0211, 2'd0, 1'b0);
    chk("t1_row0", bus.board[15:0] & 16'h00FF, 16'h0022);
    run_move(64'h0211, 2'd1, 1'b0);
    chk("t2_row0", bus.board[15:0] & 16'hFF00, 16'h2200);
    run_move(64'h0001_0001, 2'd2, 1'b0);
    chk("t3_up_cell00", 64'(bus.board[3:0]), 64'd2);
    run_move(64'h0001_0001, 2'd3, 1'b0);
    chk("t3_down_cell30", 64'(bus.board[51:48]), 64'd2);
    run_move(64'h0021, 2'd0, 1'b0);
    chk("t4_board", bus.board, 64'h0021);

    b = '0;
    for (int k = 0; k < 16; k++) b[k*4 +: 4] = (((k / 4) + (k % 4)) % 2 == 1) ? 4'd1 : 4'd2;
    for (int d = 0; d < 4; d++) begin
      run_move(b, 2'(d), 1'b0);
      chk("full_no_move", 64'(bus.moved), 64'd0);
    end

    drive_load(64'h00AA);
    chk("pre_win", 64'(bus.win), 64'd0);
    run_move(64'h00AA, 2'd0, 1'b1);
    chk("t5_cell0", 64'(bus.board[3:0]), 64'd11);
    chk("t5_win", 64'(bus.win), 64'd1);

    // Load and start together: load wins, no move follows.
    bus.load       = 1'b1;
    bus.load_board = 64'h0011;
    bus.start      = 1'b1;
    bus.dir        = 2'd0;
    @(negedge clk);
    bus.load  = 1'b0;
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("load_start_board", bus.board, 64'h0011);
    chk("load_start_busy", 64'(bus.busy), 64'd0);

    // Load abort two cycles into a move.
    drive_load(64'h0211);
    issue_start(64'h0211, 2'd0);
    @(negedge clk);
    bus.load       = 1'b1;
    bus.load_board = 64'h1234_0000_5678;
    sb.delete();
    @(negedge clk);
    bus.load = 1'b0;
    chk("abort_load_board", bus.board, 64'h1234_0000_5678);
    chk("abort_load_busy", 64'(bus.busy), 64'd0);
    repeat (25) @(negedge clk);
    chk("abort_load_moved", 64'(bus.moved), 64'd0);

    // Reset abort three cycles into a move.
    drive_load(64'h0211);
    issue_start(64'h0211, 2'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_rst_board", bus.board, 64'd0);
    chk("abort_rst_busy", 64'(bus.busy), 64'd0);
    chk("abort_rst_moved", 64'(bus.moved), 64'd0);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);

    spawn_trial(ra);
    spawn_trial(rb);
    chk("spawn_repeat", rb, ra);

    for (int n = 0; n < 40; n++) begin
      b = '0;
      for (int k = 0; k < 16; k++) begin
        rv = int'($urandom_range(0, 9));
        b[k*4 +: 4] = (rv < 4) ? 4'd0 : 4'(rv - 3);
      end
      run_move(b, 2'($urandom_range(0, 3)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
